angle_index_counter: RTL and testbench
======================================

// Module: angle_index_counter
// PURPOSE
//  Sequential angle-index generator feeding decoder_8_row_column: turns angle-step pulses and a
//  once-per-revolution reference mark into an 8-bit wrapping index.
//  index[7:4] selects the decoder row and index[3:0] selects the decoder column.
//  Tracks sync, detects missing/extra reference marks and stalled tick streams.
// PARAMETERS
//  IDX_W  8   index width; must stay 8 to match the downstream row/column decoder
//  TMO_W  16  width of the tick-to-tick watchdog counter and the timeout input
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  n_rst        in   1      asynchronous active-low reset
//  enable       in   1      1 = run; 0 = return to IDLE and clear status
//  tick         in   1      1-clk angle-step pulse
//  sync         in   1      1-clk reference-mark pulse (gap detected)
//  top_idx      in   IDX_W  last index before wrap (teeth-per-rev minus 1)
//  timeout      in   TMO_W  max clocks between ticks in RUN; 0 = watchdog off
//  index        out  IDX_W  current angle index (to decoder in)
//  index_valid  out  1      1 only in RUN
//  wrap         out  1      1-clk pulse when index goes top -> 0
//  sync_err     out  1      sticky error flag; cleared only by enable=0
//  state        out  2      FSM state, for debug/status register
// BEHAVIOUR
//  Reset (n_rst=0, async):
//   - state=IDLE; index=0; index_valid=0; wrap=0; sync_err=0; top shadow=0; watchdog=0.
//  Timing:
//   - All outputs are registered.
//   - index changes on the edge that samples tick=1, so tick -> index has 1-clk latency.
//  States:
//   - IDLE=0, WAIT_SYNC=1, RUN=2, ERR=3.
//  Transitions:
//   - enable=0 in any state -> IDLE on the next edge. index=0; index_valid, wrap, sync_err cleared.
//   - IDLE & enable=1 -> WAIT_SYNC.
//   - WAIT_SYNC: ticks are ignored. sync=1 -> RUN with index=0; top_idx is latched into the
//     top shadow. sync and tick in the same clk: sync wins and the tick is dropped.
//   - RUN, tick only: index+1. If index==shadow, index=0 instead, wrap=1 and top_idx is re-latched.
//   - RUN, tick & sync together with index==shadow: a correct wrap, handled as above; no error.
//   - RUN, sync under any other condition -> ERR, sync_err=1. This covers a sync without a tick,
//     and a sync arriving when index!=shadow.
//   - RUN, watchdog: counts clocks since the last tick; a tick resets it to 0.
//     When it reaches timeout!=0 -> ERR, sync_err=1. The counter saturates at all-ones.
//   - ERR: index is frozen, index_valid=0, ticks are ignored.
//     sync=1 -> RUN with index=0 (resync); sync_err stays set.
//  Boundary conditions:
//   - top_idx changes mid-revolution: no effect until the next wrap or resync.
//   - top_idx=0: every tick wraps, so wrap pulses on every tick.
//   - Index arithmetic is modulo 2^IDX_W. With shadow=255 the wrap is 255 -> 0.
//   - The watchdog is held at 0 outside RUN.
//   - n_rst asserted mid-RUN: all outputs clear immediately, without waiting for clk.
// STRUCTURE
//  hwag_pkg:
//   - typedef enum logic [1:0] hwag_idx_state_t {IDLE, WAIT_SYNC, RUN, ERR}
//   - localparam HWAG_IDX_W = 8
//   - localparam HWAG_TMO_W = 16
//  Sub-module tick_watchdog (clk, n_rst, clr, run, limit, expired): a saturating counter
//  plus a compare against limit; everything else stays in this module.
// TESTING
//  T1 reset: n_rst=0 mid-RUN at index 0x2A -> index=0, state=IDLE and index_valid=0 with no clk edge.
//  T2 normal rev: top_idx=57, sync, then 58 ticks ->
//     - index counts 0..57 then 0; wrap pulses once on the 58th tick.
//     - sync with that tick -> sync_err=0.
//  T3 early sync: in RUN, sync at index=30 -> state=ERR, sync_err=1, index stays 30.
//     A later sync -> RUN, index=0, sync_err still 1.
//  T4 watchdog: timeout=100, no tick for 100 clks -> ERR at clk 100.
//     With timeout=0, 70000 idle clks -> state stays RUN.
//  T5 collision and top change:
//     - tick and sync in the same clk in WAIT_SYNC -> index=0, not 1.
//     - top_idx 57 -> 9 at index 20 -> wrap still happens at 57; the next revolution wraps at 9.
//  T6 enable drop in ERR -> IDLE and sync_err=0.
//     Decoder cross-check: index 0xA3 -> row=0x0400, column=0x0008.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and widths for the angle-index generator.
// The state encoding is also visible on the debug/status port.
package hwag_pkg;

  localparam int HWAG_IDX_W = 8;
  localparam int HWAG_TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2,
    ERR       = 2'd3
  } hwag_idx_state_t;

  // Index advance with wrap at the latched top value.
  function automatic logic [HWAG_IDX_W-1:0] idx_advance(input logic [HWAG_IDX_W-1:0] idx,
                                                        input logic [HWAG_IDX_W-1:0] top);
    if (idx == top) begin
      return {HWAG_IDX_W{1'b0}};
    end else begin
      return idx + {{(HWAG_IDX_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/tick_watchdog.sv
// Saturating clocks-since-last-tick counter with a compare against a limit.
// expired flags the edge on which the count would reach the limit.
module tick_watchdog
  import hwag_pkg::*;
#(
  parameter int W = HWAG_TMO_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         run,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + W'(1);
    if (!run || clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_inc;
    end
    expired = run && !clr && (limit != '0) && (cnt_inc >= limit);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/angle_index_counter.sv
// Angle-index generator: turns tick/sync pulses into a wrapping index for the
// row/column decoder, tracking sync and flagging missing/extra marks and stalls.
module angle_index_counter
  import hwag_pkg::*;
#(
  parameter int IDX_W = HWAG_IDX_W,
  parameter int TMO_W = HWAG_TMO_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             tick,
  input  logic             sync,
  input  logic [IDX_W-1:0] top_idx,
  input  logic [TMO_W-1:0] timeout,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             wrap,
  output logic             sync_err,
  output logic [1:0]       state
);

  hwag_idx_state_t  state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] top_q, top_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             wd_expired;
  logic             at_top;

  tick_watchdog #(.W(TMO_W)) u_wd (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (tick),
    .run     (enable && (state_q == RUN)),
    .limit   (timeout),
    .expired (wd_expired)
  );

  assign at_top = (index_q == top_q);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    top_d   = top_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (!enable) begin
      state_d = IDLE;
      index_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_SYNC;
        end
        WAIT_SYNC, ERR: begin
          if (sync) begin
            state_d = RUN;
            index_d = '0;
            top_d   = top_idx;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          // A sync is only legal when it coincides with the wrapping tick.
          if (sync && !(tick && at_top)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (tick) begin
            index_d = idx_advance(index_q, top_q);
            if (at_top) begin
              wrap_d = 1'b1;
              top_d  = top_idx;
            end else begin
              wrap_d = 1'b0;
            end
          end else if (wd_expired) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          index_d = '0;
        end
      endcase
    end
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      index_q <= '0;
      top_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      top_q   <= top_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign index       = index_q;
  assign index_valid = valid_q;
  assign wrap        = wrap_q;
  assign sync_err    = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_angle_index_counter.sv
// Randomized and directed bench for angle_index_counter against a rule-level model.
module tb_angle_index_counter;

  logic        clk;
  logic        n_rst;
  logic        enable;
  logic        tick;
  logic        sync;
  logic [7:0]  top_idx;
  logic [15:0] timeout;
  logic [7:0]  index;
  logic        index_valid;
  logic        wrap;
  logic        sync_err;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integers, states 0=IDLE 1=WAIT_SYNC 2=RUN 3=ERR
  int m_st, m_idx, m_top, m_err, m_wrap, m_quiet;

  angle_index_counter dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .tick        (tick),
    .sync        (sync),
    .top_idx     (top_idx),
    .timeout     (timeout),
    .index       (index),
    .index_valid (index_valid),
    .wrap        (wrap),
    .sync_err    (sync_err),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_top = 0; m_err = 0; m_wrap = 0; m_quiet = 0;
  endtask

  task automatic model_step();
    m_wrap = 0;
    if (!enable) begin
      m_st = 0; m_idx = 0; m_err = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 || m_st == 3) begin
      if (sync) begin
        m_st = 2; m_idx = 0; m_top = int'(top_idx);
      end
    end else begin
      if (sync && !(tick && m_idx == m_top)) begin
        m_st = 3; m_err = 1;
      end else if (tick) begin
        m_quiet = 0;
        if (m_idx == m_top) begin
          m_idx = 0; m_wrap = 1; m_top = int'(top_idx);
        end else begin
          m_idx = (m_idx + 1) % 256;
        end
      end else begin
        m_quiet = (m_quiet < 65535) ? m_quiet + 1 : 65535;
        if (timeout != 16'd0 && m_quiet >= int'(timeout)) begin
          m_st = 3; m_err = 1;
        end
      end
    end
    if (m_st != 2) m_quiet = 0;
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_st));
    chk("index", 32'(index), 32'(m_idx));
    chk("valid", 32'(index_valid), 32'(m_st == 2));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("sync_err", 32'(sync_err), 32'(m_err));
  endtask

  task automatic step(input logic en, input logic tk, input logic sy);
    enable = en; tick = tk; sync = sy;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] row, col;
    logic tk, sy, en;
    n_rst = 1'b0; enable = 1'b0; tick = 1'b0; sync = 1'b0;
    top_idx = 8'd255; timeout = 16'd0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    n_rst = 1'b1;

    // T1: asynchronous reset mid-RUN at index 0x2A
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    ticks(42);
    chk("t1_pre_idx", 32'(index), 32'h2A);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("t1_idx", 32'(index), 32'h0);
    chk("t1_state", 32'(state), 32'h0);
    chk("t1_valid", 32'(index_valid), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // T2: normal revolution, sync on the wrapping tick
    top_idx = 8'd57;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    ticks(57);
    chk("t2_idx57", 32'(index), 32'd57);
    step(1'b1, 1'b1, 1'b1);
    chk("t2_wrap", 32'(wrap), 32'h1);
    chk("t2_idx0", 32'(index), 32'h0);
    chk("t2_err", 32'(sync_err), 32'h0);

    // T3: early sync at index 30, then resync
    ticks(30);
    step(1'b1, 1'b0, 1'b1);
    chk("t3_state", 32'(state), 32'd3);
    chk("t3_idx", 32'(index), 32'd30);
    chk("t3_err", 32'(sync_err), 32'h1);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_frozen", 32'(index), 32'd30);
    step(1'b1, 1'b0, 1'b1);
    chk("t3_resync", 32'(state), 32'd2);
    chk("t3_resync_idx", 32'(index), 32'h0);
    chk("t3_sticky", 32'(sync_err), 32'h1);

    // T4: watchdog expiry after 100 tick-less clocks
    timeout = 16'd100;
    for (int k = 0; k < 99; k++) step(1'b1, 1'b0, 1'b0);
    chk("t4_pre", 32'(state), 32'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_expire", 32'(state), 32'd3);

    // T6: enable drop in ERR
    step(1'b0, 1'b0, 1'b0);
    chk("t6_state", 32'(state), 32'h0);
    chk("t6_err", 32'(sync_err), 32'h0);

    // T4b: watchdog disabled, long stall stays in RUN
    timeout = 16'd0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 70000; k++) step(1'b1, 1'b0, 1'b0);
    chk("t4_off", 32'(state), 32'd2);

    // T5: tick/sync collision and mid-revolution top change
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    top_idx = 8'd57;
    step(1'b1, 1'b1, 1'b1);
    chk("t5_collide", 32'(index), 32'h0);
    ticks(20);
    top_idx = 8'd9;
    ticks(37);
    chk("t5_idx57", 32'(index), 32'd57);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_wrap57", 32'(wrap), 32'h1);
    ticks(9);
    chk("t5_idx9", 32'(index), 32'd9);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_wrap9", 32'(wrap), 32'h1);
    chk("t5_idx0", 32'(index), 32'h0);

    // Decoder cross-check at index 0xA3
    top_idx = 8'd255;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    ticks(163);
    row = 16'd1 << index[7:4];
    col = 16'd1 << index[3:0];
    chk("dec_row", 32'(row), 32'h0400);
    chk("dec_col", 32'(col), 32'h0008);
    ticks(92);
    step(1'b1, 1'b1, 1'b0);
    chk("wrap255", 32'(wrap), 32'h1);

    // Randomized traffic
    timeout = 16'd0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) == 0) top_idx = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      en = ($urandom_range(0, 199) != 0);
      tk = ($urandom_range(0, 2) == 0);
      sy = ($urandom_range(0, 59) == 0);
      if (m_st == 2 && m_idx == m_top && tk && $urandom_range(0, 1) == 1) sy = 1'b1;
      step(en, tk, sy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
